// File: rtl/ni_packet_controller.sv
`default_nettype none
// ============================================================================
// Module   : ni_packet_controller
// Purpose  : Network-interface sequencer between the MIPS core and its NoC
//            router port. TX turns one core word into a head+tail packet;
//            RX reassembles head+tail packets into a small FIFO for the core.
// Ports    : clk, rst_n            - clock, async active-low reset
//            proc_valid/proc_data/dest_add, mips_ni   - core -> NI word
//            data_valid/ni_data_out/ni_src_out, proc_ready_in - NI -> core
//            tx_flit/tx_valid/tx_ready               - NI -> router
//            rx_flit/rx_valid/rx_ready               - router -> NI
//            rx_count, rx_err                        - FIFO level, error pulse
// Revision : 1.0 - initial release
// ============================================================================
module ni_packet_controller #(
   parameter int         DATA_W   = 32,
   parameter logic [1:0] NODE_ID  = 2'd0,
   parameter int         RX_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          proc_valid,
   input  logic [DATA_W-1:0]             proc_data,
   input  logic [1:0]                    dest_add,
   output logic                          mips_ni,
   output logic                          data_valid,
   output logic [DATA_W-1:0]             ni_data_out,
   output logic [1:0]                    ni_src_out,
   input  logic                          proc_ready_in,
   output logic [DATA_W+1:0]             tx_flit,
   output logic                          tx_valid,
   input  logic                          tx_ready,
   input  logic [DATA_W+1:0]             rx_flit,
   input  logic                          rx_valid,
   output logic                          rx_ready,
   output logic [$clog2(RX_DEPTH):0]     rx_count,
   output logic                          rx_err
);

   localparam int         AW      = $clog2(RX_DEPTH);
   localparam int         CW      = AW + 1;
   localparam logic [1:0] FT_HEAD = 2'b01;
   localparam logic [1:0] FT_TAIL = 2'b10;

   typedef enum logic [1:0] {T_IDLE = 2'd0, T_HEAD = 2'd1, T_TAIL = 2'd2} tx_state_t;
   typedef enum logic [0:0] {R_HEAD = 1'b0, R_TAIL = 1'b1} rx_state_t;

   tx_state_t           tx_state;
   logic [DATA_W-1:0]   tx_data;

   rx_state_t           rx_state;
   logic [1:0]          rx_src;
   logic [DATA_W+1:0]   mem [RX_DEPTH];   // {src, data}
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;

   // ------------------------------------------------------------------------
   // TX: the head flit is built at acceptance so only the data word needs
   // to be held for the tail.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state <= T_IDLE;
         tx_data  <= '0;
         tx_flit  <= '0;
         tx_valid <= 1'b0;
         mips_ni  <= 1'b1;
      end else begin
         case (tx_state)
            T_IDLE: begin
               if (proc_valid) begin
                  tx_data  <= proc_data;
                  tx_flit  <= {FT_HEAD, {(DATA_W-4){1'b0}}, dest_add, NODE_ID};
                  tx_valid <= 1'b1;
                  mips_ni  <= 1'b0;
                  tx_state <= T_HEAD;
               end
            end
            T_HEAD: begin
               if (tx_ready) begin
                  tx_flit  <= {FT_TAIL, tx_data};
                  tx_state <= T_TAIL;
               end
            end
            T_TAIL: begin
               if (tx_ready) begin
                  tx_flit  <= '0;
                  tx_valid <= 1'b0;
                  mips_ni  <= 1'b1;
                  tx_state <= T_IDLE;
               end
            end
            default: begin
               tx_flit  <= '0;
               tx_valid <= 1'b0;
               mips_ni  <= 1'b1;
               tx_state <= T_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // RX
   // ------------------------------------------------------------------------
   logic [1:0] rx_type;
   logic       rx_fire;
   logic       rx_full;
   logic       push;
   logic       pop;

   assign rx_type    = rx_flit[DATA_W+1:DATA_W];
   assign rx_full    = (rx_count == CW'(RX_DEPTH));
   // Heads never need storage; only a pending tail is throttled by FIFO
   // space, and that uses the registered count (no pop bypass).
   assign rx_ready   = (rx_state == R_HEAD) || !rx_full;
   assign rx_fire    = rx_valid && rx_ready;
   assign push       = rx_fire && (rx_state == R_TAIL) && (rx_type == FT_TAIL);
   assign data_valid = (rx_count != '0);
   assign pop        = data_valid && proc_ready_in;

   assign ni_data_out = data_valid ? mem[rd_ptr][DATA_W-1:0]      : '0;
   assign ni_src_out  = data_valid ? mem[rd_ptr][DATA_W+1:DATA_W] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state <= R_HEAD;
         rx_src   <= '0;
         rx_err   <= 1'b0;
      end else begin
         rx_err <= 1'b0;
         if (rx_fire) begin
            case (rx_state)
               R_HEAD: begin
                  if (rx_type == FT_HEAD) begin
                     rx_src   <= rx_flit[1:0];
                     rx_state <= R_TAIL;
                  end else begin
                     rx_err <= 1'b1;
                  end
               end
               R_TAIL: begin
                  if (rx_type == FT_TAIL) begin
                     rx_state <= R_HEAD;
                  end else if (rx_type == FT_HEAD) begin
                     // A fresh head restarts the packet with the new source.
                     rx_src <= rx_flit[1:0];
                     rx_err <= 1'b1;
                  end else begin
                     rx_err <= 1'b1;
                  end
               end
               default: rx_state <= R_HEAD;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rx_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   rx_count <= rx_count + CW'(1);
            2'b01:   rx_count <= rx_count - CW'(1);
            default: rx_count <= rx_count;
         endcase
      end
   end

   // Storage needs no reset: the read outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {rx_src, rx_flit[DATA_W-1:0]};
   end

endmodule
`default_nettype wire

// File: doc/ni_packet_controller.md
Name: ni_packet_controller

Overview:
- Sequences the network interface (NI) between the MIPS core and its NoC router port.
- TX path: accepts one 32-bit word plus a 2-bit destination from the core via the valid/accept handshake, then emits a two-flit packet (head, tail) to the router.
- RX path: reassembles head+tail packets from the router into a small FIFO and presents {source, data} to the core.
- The decode stage drives proc_valid/dest_add on ni_out and consumes data_valid/reg_en on ni_in.

Parameters:
DATA_W, 32, payload width of the core word and of the flit payload.
NODE_ID, 2'd0, this node's 2-bit address, inserted as source in head flits.
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2).

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
proc_valid  in  1  core presents a word to send (ni_out).
proc_data  in  DATA_W  word to send.
dest_add  in  2  destination node address.
mips_ni  out  1  NI can accept a word this cycle.
data_valid  out  1  RX word available to core.
ni_data_out  out  DATA_W  RX word at FIFO head.
ni_src_out  out  2  source node of RX word at FIFO head.
proc_ready_in  in  1  core accepts RX word (pop).
tx_flit  out  DATA_W+2  {type[1:0], payload}; type 2'b01=head, 2'b10=tail.
tx_valid  out  1  tx_flit valid.
tx_ready  in  1  router accepts tx_flit.
rx_flit  in  DATA_W+2  incoming flit, same format.
rx_valid  in  1  rx_flit valid.
rx_ready  out  1  controller accepts rx_flit.
rx_count  out  clog2(RX_DEPTH)+1  RX FIFO occupancy.
rx_err  out  1  one-cycle pulse on protocol error.

Behaviour:
- Reset: TX->T_IDLE, RX->R_HEAD, FIFO empty. Outputs: mips_ni=1, tx_valid=0, tx_flit=0, data_valid=0, ni_data_out=0, ni_src_out=0, rx_ready=1, rx_count=0, rx_err=0. Reset mid-packet discards all partial TX/RX state; no flit is completed.
- Head payload: bits[3:2]=dest, bits[1:0]=src, upper bits zero. Tail payload: data word.
- TX FSM, states T_IDLE, T_HEAD, T_TAIL:
  - T_IDLE: mips_ni=1, tx_valid=0. If proc_valid=1, latch proc_data and dest_add and go to T_HEAD. Inputs are ignored in all other states.
  - T_HEAD: mips_ni=0, tx_valid=1, tx_flit={01, head(dest, NODE_ID)}. On tx_ready=1 go to T_TAIL; otherwise hold with the flit stable.
  - T_TAIL: tx_valid=1, tx_flit={10, latched data}. On tx_ready=1 go to T_IDLE.
  - Minimum 3 cycles per packet. The first flit appears the cycle after acceptance.
  - dest==NODE_ID is still sent; the router loops it back.
- RX FSM, states R_HEAD, R_TAIL. A flit transfers when rx_valid && rx_ready.
  - R_HEAD: rx_ready=1. A head flit latches src=payload[1:0] and goes to R_TAIL. A tail or other type is dropped, rx_err pulses, and the state stays R_HEAD.
  - R_TAIL: rx_ready = FIFO not full, evaluated on registered count with no same-cycle pop bypass.
    - Tail flit: push {src, payload} and go to R_HEAD.
    - Head flit: discard the old src, latch the new src, stay in R_TAIL, rx_err pulses.
    - Type 00/11: dropped, rx_err pulses, stay in R_TAIL.
  - Flits are accepted independently of TX activity; full duplex.
- RX FIFO:
  - data_valid = count!=0. ni_data_out/ni_src_out show the head entry and are 0 when empty.
  - Pop when data_valid && proc_ready_in.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo RX_DEPTH.
  - Pop when empty is ignored.
  - Push is impossible when full because rx_ready=0.
- rx_err is registered and high for exactly one cycle per error event.

Test Plan:
- Reset then proc_valid=1, proc_data=0xDEADBEEF, dest_add=2, NODE_ID=1, tx_ready=1 -> next cycle tx_flit={01, 0x00000009}, then {10, 0xDEADBEEF}, then mips_ni=1. mips_ni=0 for 2 cycles.
- Same TX with tx_ready=0 for 3 cycles in T_HEAD -> head flit held stable, mips_ni=0 throughout, and a second proc_valid is ignored.
- RX head (src=3) + tail 0x12345678 with proc_ready_in=0 -> data_valid=1, ni_data_out=0x12345678, ni_src_out=3, rx_count=1. Pulse proc_ready_in -> data_valid=0.
- Push 4 packets with no pops -> rx_count=4 and rx_ready=0 in R_TAIL on the 5th packet's tail. One pop -> tail accepted the next cycle. Order is preserved across wrap.
- Tail flit in R_HEAD -> dropped, rx_err 1 cycle, FIFO unchanged. Head, head(src=2), tail 0xAA -> rx_err once, entry src=2, data 0xAA.
- Assert rst_n=0 during T_TAIL and during R_TAIL -> tx_valid=0 and mips_ni=1 immediately. After release, a fresh tail flit is dropped with rx_err.
